slink_generic_rx_router: RTL and testbench
==========================================

Name: slink_generic_rx_router

Overview:
- Receive-side counterpart of the generic TX channel arbiter. Sits between the S-Link RX application interface and N application channels.
- Decodes each packet header, picks one destination channel by matching the data ID against a per-channel programmable ID, and steers the header plus all payload beats of that packet to that channel.
- Unmatched packets are dropped.
- All channel outputs are registered, giving 1-cycle latency.

Parameters:
- NUM_CHANNELS, 8, number of destination channels (>=2).
- RX_APP_DATA_WIDTH, 64, payload bits per beat; multiple of 8. BPB = RX_APP_DATA_WIDTH/8 bytes per beat.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  router enable; asynchronous, demetted internally with slink_demet_reset
- ch_data_id  input  NUM_CHANNELS*8  data ID claimed by each channel; channel n uses bits [n*8+7:n*8]
- ch_id_valid  input  NUM_CHANNELS  channel n participates in matching only when its bit is 1
- rx_sop  input  1  header cycle marker; qualified by rx_valid
- rx_data_id  input  8  packet data ID; valid on the header cycle
- rx_word_count  input  16  header payload field: byte count (long packets) or short payload
- rx_app_data  input  RX_APP_DATA_WIDTH  payload beat
- rx_valid  input  1  beat valid
- rx_crc_corrupted  input  1  CRC error flag, valid with the last payload beat
- rx_sop_ch  output  NUM_CHANNELS  one-hot header strobe to the selected channel
- rx_valid_ch  output  NUM_CHANNELS  one-hot payload beat strobe
- rx_data_id_o  output  8  registered header ID, shared by all channels
- rx_word_count_o  output  16  registered header word count, shared
- rx_app_data_o  output  RX_APP_DATA_WIDTH  registered payload, shared
- rx_crc_corrupted_ch  output  NUM_CHANNELS  one-hot CRC error, aligned with the last beat
- drop_count  output  16  packets dropped because no channel matched
- proto_err_count  output  16  packets truncated by an early SOP

Behaviour:
- Reset: all outputs are 0, the FSM is IDLE, and the remaining-byte counter is 0.
- Short vs long packets:
  - Short: rx_data_id <= 8'h1F, or rx_word_count == 0. The packet is the header only.
  - Long: every other header. It is followed by ceil(rx_word_count/BPB) payload beats, each marked rx_valid=1 and rx_sop=0.
- Channel match: the lowest index n with ch_id_valid[n] && ch_data_id[n]==rx_data_id wins. If no channel matches, the packet is dropped: no channel strobes for the header or any of its beats, and drop_count increments by 1, saturating at 16'hFFFF.
- FSM, state IDLE:
  - rx_sop&&rx_valid with a short packet: pulse rx_sop_ch[sel] for one cycle and stay in IDLE.
  - rx_sop&&rx_valid with a long packet: pulse rx_sop_ch[sel], latch sel and remaining=rx_word_count, and go to PAYLOAD.
  - rx_valid without rx_sop: ignore the beat.
- FSM, state PAYLOAD:
  - Each rx_valid beat drives rx_valid_ch[sel]=1 and rx_app_data_o=rx_app_data on the following cycle.
  - On each beat: if remaining <= BPB the beat is the last one; forward rx_crc_corrupted onto rx_crc_corrupted_ch[sel], set remaining=0 and go to IDLE. Otherwise remaining -= BPB.
  - Idle cycles (rx_valid=0) hold the FSM state.
- Early SOP: rx_sop&&rx_valid while in PAYLOAD ends the current packet without a last-beat strobe and increments proto_err_count. The new header is decoded in the same cycle exactly as in IDLE, with no lost cycle.
- Hold values: rx_data_id_o and rx_word_count_o update only on accepted headers, including dropped ones. rx_app_data_o updates on every payload beat. All three hold otherwise.
- One-hot rule: at most one bit of rx_sop_ch | rx_valid_ch is set per cycle.
- Disable: while demetted enable=0:
  - The FSM is forced to IDLE and all strobes are 0.
  - Inputs are ignored.
  - Counters hold their value.
  - A packet in flight when enable falls is abandoned silently. The next packet is accepted only after a fresh SOP following re-enable.
- Configuration changes: ch_data_id and ch_id_valid are sampled only on header cycles. Changing them mid-packet has no effect on the packet in flight.

Optional Feature:
- SLINK_RX_ROUTER_STATS_EN defined: drop_count and proto_err_count are implemented as described, as saturating counters that are cleared only by reset.
- Not defined: both outputs are tied to 16'h0 and no counter flops are built. Drop and truncation behaviour is otherwise identical.

Test Plan:
- Short packet: ch_data_id[3]=8'h05 valid, header ID 8'h05, wc=16'h1234 -> next cycle rx_sop_ch=8'b0000_1000, rx_word_count_o=16'h1234, no rx_valid_ch pulse, FSM stays IDLE.
- Long packet: ch2 ID 8'h2A, wc=20, BPB=8 -> rx_sop_ch[2] once, then exactly 3 rx_valid_ch[2] pulses; rx_crc_corrupted=1 on the 3rd beat -> rx_crc_corrupted_ch[2]=1 on that beat only.
- Overlapping claims: channels 1 and 6 both claim 8'h30 -> only channel 1 strobes. Clearing ch_id_valid[1] -> the next 8'h30 packet goes to channel 6.
- Unmatched ID: header ID 8'h77 with wc=16 -> zero strobes on all channels, drop_count 0->1 (stats build), stays 0 (non-stats build).
- Early SOP: long wc=64 to ch0, new SOP (ID of ch4, short) after 2 beats -> ch0 gets 2 beats and no CRC strobe, rx_sop_ch[4] next cycle, proto_err_count=1.
- Disable mid-packet: drop enable after beat 1 of a 4-beat packet, re-enable, send a short packet -> the remaining beats are ignored and the short packet routes correctly.

Source files
------------

// File: rtl/slink_generic_rx_router.sv
// slink_generic_rx_router
// Receive-side router: decodes each S-Link RX packet header, selects the
// lowest-index channel whose programmed data ID matches, and steers the
// header strobe plus every payload beat of that packet to that channel.
// Unmatched packets are dropped. All channel-facing outputs are registered,
// so there is one cycle of latency.
// Optional build macro: SLINK_RX_ROUTER_STATS_EN enables the saturating
// drop_count / proto_err_count counters; otherwise both read as 16'h0.
module slink_generic_rx_router #(
  parameter int NUM_CHANNELS      = 8,
  parameter int RX_APP_DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CHANNELS*8-1:0]     ch_data_id,
  input  logic [NUM_CHANNELS-1:0]       ch_id_valid,
  input  logic                          rx_sop,
  input  logic [7:0]                    rx_data_id,
  input  logic [15:0]                   rx_word_count,
  input  logic [RX_APP_DATA_WIDTH-1:0]  rx_app_data,
  input  logic                          rx_valid,
  input  logic                          rx_crc_corrupted,
  output logic [NUM_CHANNELS-1:0]       rx_sop_ch,
  output logic [NUM_CHANNELS-1:0]       rx_valid_ch,
  output logic [7:0]                    rx_data_id_o,
  output logic [15:0]                   rx_word_count_o,
  output logic [RX_APP_DATA_WIDTH-1:0]  rx_app_data_o,
  output logic [NUM_CHANNELS-1:0]       rx_crc_corrupted_ch,
  output logic [15:0]                   drop_count,
  output logic [15:0]                   proto_err_count
);

  localparam int          SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [15:0] BPB   = 16'(RX_APP_DATA_WIDTH / 8);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic [SEL_W-1:0]              r_sel, w_sel_nxt;
  logic [15:0]                   r_remaining, w_remaining_nxt;
  logic                          r_en_meta, r_en;

  logic [NUM_CHANNELS-1:0]       r_sop_ch, w_sop_ch_nxt;
  logic [NUM_CHANNELS-1:0]       r_valid_ch, w_valid_ch_nxt;
  logic [NUM_CHANNELS-1:0]       r_crc_ch, w_crc_ch_nxt;
  logic [7:0]                    r_data_id, w_data_id_nxt;
  logic [15:0]                   r_wc, w_wc_nxt;
  logic [RX_APP_DATA_WIDTH-1:0]  r_data, w_data_nxt;

  logic                          w_hdr, w_short, w_match, w_hit;
  logic [SEL_W-1:0]              w_match_idx;
  logic                          w_drop_inc, w_proto_inc;

  assign w_hdr   = rx_sop & rx_valid;
  assign w_short = (rx_data_id <= 8'h1F) || (rx_word_count == 16'h0000);

  // Two-flop synchronizer for the asynchronous enable input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_meta <= 1'b0;
      r_en      <= 1'b0;
    end else begin
      r_en_meta <= enable;
      r_en      <= r_en_meta;
    end
  end

  // Lowest-index channel whose valid programmed ID equals the header ID
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_hit       = 1'b0;
    for (int n = NUM_CHANNELS - 1; n >= 0; n--) begin
      w_hit       = ch_id_valid[n] && (ch_data_id[n*8 +: 8] == rx_data_id);
      w_match_idx = w_hit ? SEL_W'(n) : w_match_idx;
      w_match     = w_match | w_hit;
    end
  end

  // FSM next state and next values of every registered output
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_remaining_nxt = r_remaining;
    w_sop_ch_nxt    = '0;
    w_valid_ch_nxt  = '0;
    w_crc_ch_nxt    = '0;
    w_data_id_nxt   = r_data_id;
    w_wc_nxt        = r_wc;
    w_data_nxt      = r_data;
    w_drop_inc      = 1'b0;
    w_proto_inc     = 1'b0;
    if (!r_en) begin
      // disabled: abandon any packet, ignore inputs
      w_state_nxt     = ST_IDLE;
      w_remaining_nxt = 16'h0000;
    end else if (w_hdr) begin
      // a header in PAYLOAD truncates the packet in flight
      w_proto_inc     = (r_state == ST_PAYLOAD);
      w_data_id_nxt   = rx_data_id;
      w_wc_nxt        = rx_word_count;
      w_state_nxt     = ST_IDLE;
      w_remaining_nxt = 16'h0000;
      if (w_match) begin
        w_sop_ch_nxt[w_match_idx] = 1'b1;
        if (w_short) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt     = ST_PAYLOAD;
          w_sel_nxt       = w_match_idx;
          w_remaining_nxt = rx_word_count;
        end
      end else begin
        // dropped packet stays in IDLE so its beats are ignored
        w_drop_inc = 1'b1;
      end
    end else if (rx_valid && (r_state == ST_PAYLOAD)) begin
      w_valid_ch_nxt[r_sel] = 1'b1;
      w_data_nxt            = rx_app_data;
      if (r_remaining <= BPB) begin
        w_crc_ch_nxt[r_sel] = rx_crc_corrupted;
        w_remaining_nxt     = 16'h0000;
        w_state_nxt         = ST_IDLE;
      end else begin
        w_remaining_nxt = r_remaining - BPB;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state, selected channel and remaining-byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_remaining <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Registered channel strobes and shared header/payload outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sop_ch   <= '0;
      r_valid_ch <= '0;
      r_crc_ch   <= '0;
      r_data_id  <= 8'h00;
      r_wc       <= 16'h0000;
      r_data     <= '0;
    end else begin
      r_sop_ch   <= w_sop_ch_nxt;
      r_valid_ch <= w_valid_ch_nxt;
      r_crc_ch   <= w_crc_ch_nxt;
      r_data_id  <= w_data_id_nxt;
      r_wc       <= w_wc_nxt;
      r_data     <= w_data_nxt;
    end
  end

  assign rx_sop_ch           = r_sop_ch;
  assign rx_valid_ch         = r_valid_ch;
  assign rx_crc_corrupted_ch = r_crc_ch;
  assign rx_data_id_o        = r_data_id;
  assign rx_word_count_o     = r_wc;
  assign rx_app_data_o       = r_data;

`ifdef SLINK_RX_ROUTER_STATS_EN
  logic [15:0] r_drop_cnt, r_proto_cnt;

  // Saturating drop and truncation counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt  <= 16'h0000;
      r_proto_cnt <= 16'h0000;
    end else begin
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'h0001;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
      if (w_proto_inc && (r_proto_cnt != 16'hFFFF)) begin
        r_proto_cnt <= r_proto_cnt + 16'h0001;
      end else begin
        r_proto_cnt <= r_proto_cnt;
      end
    end
  end

  assign drop_count      = r_drop_cnt;
  assign proto_err_count = r_proto_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats  = w_drop_inc ^ w_proto_inc;
  assign drop_count      = 16'h0000;
  assign proto_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_slink_generic_rx_router.sv
// Scoreboard bench for slink_generic_rx_router (8 channels, 64-bit beats).
module tb_slink_generic_rx_router;
  localparam int NCH = 8;
  localparam int DW  = 64;

  logic              clk = 1'b0;
  logic              reset, enable;
  logic [NCH*8-1:0]  ch_data_id;
  logic [NCH-1:0]    ch_id_valid;
  logic              rx_sop, rx_valid, rx_crc_corrupted;
  logic [7:0]        rx_data_id;
  logic [15:0]       rx_word_count;
  logic [DW-1:0]     rx_app_data;
  logic [NCH-1:0]    rx_sop_ch, rx_valid_ch, rx_crc_corrupted_ch;
  logic [7:0]        rx_data_id_o;
  logic [15:0]       rx_word_count_o, drop_count, proto_err_count;
  logic [DW-1:0]     rx_app_data_o;

  typedef struct {
    bit          is_sop;
    int          ch;
    logic [7:0]  id;
    logic [15:0] wc;
    logic [DW-1:0] data;
    bit          crc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

`ifdef SLINK_RX_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  slink_generic_rx_router #(.NUM_CHANNELS(NCH), .RX_APP_DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ch_data_id(ch_data_id), .ch_id_valid(ch_id_valid),
    .rx_sop(rx_sop), .rx_data_id(rx_data_id), .rx_word_count(rx_word_count),
    .rx_app_data(rx_app_data), .rx_valid(rx_valid), .rx_crc_corrupted(rx_crc_corrupted),
    .rx_sop_ch(rx_sop_ch), .rx_valid_ch(rx_valid_ch),
    .rx_data_id_o(rx_data_id_o), .rx_word_count_o(rx_word_count_o),
    .rx_app_data_o(rx_app_data_o), .rx_crc_corrupted_ch(rx_crc_corrupted_ch),
    .drop_count(drop_count), .proto_err_count(proto_err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NCH-1:0] oh(input int ch);
    logic [NCH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  // one input cycle; outputs for it are visible when the task returns
  task automatic drive(input bit sop, input bit vld, input logic [7:0] id,
                       input logic [15:0] wc, input logic [DW-1:0] d, input bit crc);
    rx_sop = sop; rx_valid = vld; rx_data_id = id; rx_word_count = wc;
    rx_app_data = d; rx_crc_corrupted = crc;
    @(posedge clk); #1;
    rx_sop = 1'b0; rx_valid = 1'b0; rx_crc_corrupted = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] id, input logic [15:0] wc, input int ch);
    exp_t e;
    if (ch >= 0) begin
      e.is_sop = 1'b1; e.ch = ch; e.id = id; e.wc = wc; e.data = '0; e.crc = 1'b0;
      sb.push_back(e);
    end
    drive(1'b1, 1'b1, id, wc, 64'h0, 1'b0);
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit crc, input int ch, input bit exp_crc);
    exp_t e;
    if (ch >= 0) begin
      e.is_sop = 1'b0; e.ch = ch; e.id = 8'h00; e.wc = 16'h0; e.data = d; e.crc = exp_crc;
      sb.push_back(e);
    end
    drive(1'b0, 1'b1, 8'h00, 16'h0, d, crc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 16'h0, 64'h0, 1'b0);
  endtask

  // monitor: pop and compare whenever any channel strobe is presented
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if ((rx_sop_ch | rx_valid_ch) != '0) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_strobe: got sop=%b valid=%b expected none", rx_sop_ch, rx_valid_ch);
        end else begin
          e = sb.pop_front();
          chk("sop_ch", 64'(rx_sop_ch), e.is_sop ? 64'(oh(e.ch)) : 64'h0);
          chk("valid_ch", 64'(rx_valid_ch), e.is_sop ? 64'h0 : 64'(oh(e.ch)));
          chk("crc_ch", 64'(rx_crc_corrupted_ch), e.crc ? 64'(oh(e.ch)) : 64'h0);
          if (e.is_sop) begin
            chk("data_id_o", 64'(rx_data_id_o), 64'(e.id));
            chk("word_count_o", 64'(rx_word_count_o), 64'(e.wc));
          end else begin
            chk("app_data_o", rx_app_data_o, e.data);
          end
        end
      end else if (rx_crc_corrupted_ch != '0) begin
        chk("crc_without_beat", 64'(rx_crc_corrupted_ch), 64'h0);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1;
    rx_sop = 1'b0; rx_valid = 1'b0; rx_crc_corrupted = 1'b0;
    rx_data_id = 8'h00; rx_word_count = 16'h0; rx_app_data = '0;
    // ch7..ch0 IDs
    ch_data_id  = {8'h60, 8'h30, 8'h50, 8'h11, 8'h05, 8'h2A, 8'h30, 8'h40};
    ch_id_valid = 8'hFF;
    #12;
    chk("rst_sop_ch", 64'(rx_sop_ch), 64'h0);
    chk("rst_valid_ch", 64'(rx_valid_ch), 64'h0);
    chk("rst_crc_ch", 64'(rx_crc_corrupted_ch), 64'h0);
    chk("rst_data_id", 64'(rx_data_id_o), 64'h0);
    chk("rst_wc", 64'(rx_word_count_o), 64'h0);
    chk("rst_data", rx_app_data_o, 64'h0);
    chk("rst_drop", 64'(drop_count), 64'h0);
    chk("rst_proto", 64'(proto_err_count), 64'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    idle(4);

    // short packet to ch3, then a stray beat must be ignored
    hdr(8'h05, 16'h1234, 3);
    beat(64'hDEAD_0000_0000_0001, 1'b0, -1, 1'b0);
    // SOP without valid is ignored
    drive(1'b1, 1'b0, 8'h05, 16'h0, 64'h0, 1'b0);
    idle(1);

    // long packet, wc=20 -> 3 beats; crc only reported on the last beat
    hdr(8'h2A, 16'd20, 2);
    beat(64'h1111_0000_0000_0001, 1'b0, 2, 1'b0);
    beat(64'h1111_0000_0000_0002, 1'b1, 2, 1'b0);
    beat(64'h1111_0000_0000_0003, 1'b1, 2, 1'b1);
    beat(64'h1111_0000_0000_0004, 1'b0, -1, 1'b0);
    // boundaries: wc=8 -> 1 beat, wc=9 -> 2 beats
    hdr(8'h2A, 16'd8, 2);
    beat(64'h2222_0000_0000_0001, 1'b0, 2, 1'b0);
    beat(64'h2222_0000_0000_0002, 1'b0, -1, 1'b0);
    hdr(8'h2A, 16'd9, 2);
    beat(64'h3333_0000_0000_0001, 1'b0, 2, 1'b0);
    beat(64'h3333_0000_0000_0002, 1'b1, 2, 1'b1);
    idle(1);

    // overlapping claims on 8'h30: ch1 wins, then ch6 once ch1 is invalid
    hdr(8'h30, 16'h0, 1);
    ch_id_valid[1] = 1'b0;
    hdr(8'h30, 16'h0, 6);
    ch_id_valid[1] = 1'b1;
    idle(1);

    // unmatched ID is dropped, its beats ignored, header outputs still update
    hdr(8'h77, 16'd16, -1);
    chk("drop_count", 64'(drop_count), STATS ? 64'h1 : 64'h0);
    chk("drop_data_id_o", 64'(rx_data_id_o), 64'h77);
    chk("drop_wc_o", 64'(rx_word_count_o), 64'd16);
    beat(64'h4444_0000_0000_0001, 1'b0, -1, 1'b0);
    beat(64'h4444_0000_0000_0002, 1'b1, -1, 1'b0);
    idle(1);

    // early SOP: ch0 gets 2 beats, ch4 short header in the very next cycle
    hdr(8'h40, 16'd64, 0);
    beat(64'h5555_0000_0000_0001, 1'b0, 0, 1'b0);
    beat(64'h5555_0000_0000_0002, 1'b0, 0, 1'b0);
    hdr(8'h11, 16'd5, 4);
    chk("proto_err_count", 64'(proto_err_count), STATS ? 64'h1 : 64'h0);
    beat(64'h5555_0000_0000_0003, 1'b1, -1, 1'b0);
    chk("drop_after_proto", 64'(drop_count), STATS ? 64'h1 : 64'h0);
    idle(1);

    // config change mid-packet does not affect the packet in flight
    hdr(8'h50, 16'd16, 5);
    ch_id_valid[5] = 1'b0;
    ch_data_id[47:40] = 8'h99;
    beat(64'h6666_0000_0000_0001, 1'b0, 5, 1'b0);
    beat(64'h6666_0000_0000_0002, 1'b1, 5, 1'b1);
    ch_id_valid[5] = 1'b1;
    ch_data_id[47:40] = 8'h50;
    idle(1);

    // disable mid-packet: remaining beats abandoned, short packet routes after re-enable
    hdr(8'h60, 16'd32, 7);
    beat(64'h7777_0000_0000_0001, 1'b0, 7, 1'b0);
    enable = 1'b0;
    idle(4);
    beat(64'h7777_0000_0000_0002, 1'b0, -1, 1'b0);
    beat(64'h7777_0000_0000_0003, 1'b0, -1, 1'b0);
    hdr(8'h05, 16'h0, -1);
    beat(64'h7777_0000_0000_0004, 1'b1, -1, 1'b0);
    chk("disabled_data_hold", rx_app_data_o, 64'h7777_0000_0000_0001);
    chk("disabled_wc_hold", 64'(rx_word_count_o), 64'd32);
    enable = 1'b1;
    idle(4);
    beat(64'h7777_0000_0000_0005, 1'b0, -1, 1'b0);
    hdr(8'h05, 16'h00AB, 3);
    chk("proto_after_disable", 64'(proto_err_count), STATS ? 64'h1 : 64'h0);
    idle(3);

    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
